odu_payload_extract: RTL and testbench

- Downstream consumer of the ODU frame generator's 384-bit stream.
- Locks to frame and row boundaries.
- Checks and strips the 16-byte row overhead and the 16-byte end-of-row stuffing.
- Repacks the remaining payload bytes into gap-free 48-byte words for the OSU demapper; reports header errors, loss of frame and PSI.

---
 rtl/odu_pkg.sv | 18 +
 rtl/odu_gearbox_48b.sv | 70 +++++++
 rtl/odu_payload_extract.sv | 194 +++++++++++++++++++
 tb/tb_odu_payload_extract.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/odu_pkg.sv
// rtl/odu_pkg.sv - shared constants, row header helper and framing state for the ODU payload extractor
package odu_pkg;
    localparam int BUS_W          = 384;
    localparam int BYTES_PER_BEAT = 48;
    localparam int UNIT_BYTES     = 16;
    localparam int HDR_BYTES      = 16;
    localparam int STUFF_BYTES    = 16;
    localparam int PSI_BYTE_IDX   = 14;
    localparam int PSI_ROW        = 3;
    localparam logic [7:0] STUFF_BYTE = 8'h99;

    typedef enum logic {HUNT = 1'b0, SYNC = 1'b1} odu_state_e;

    // Row r carries header bytes 8'h11*(r+1): 8'h11, 8'h22, 8'h33, 8'h44.
    function automatic logic [7:0] hdr_byte(input logic [1:0] row);
        return 8'h11 * ({6'd0, row} + 8'd1);
    endfunction
endpackage

// File: rtl/odu_gearbox_48b.sv
// rtl/odu_gearbox_48b.sv - packs 32/48-byte payload chunks into gap-free 48-byte words
module odu_gearbox_48b
    import odu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [BUS_W-1:0] data_i,
    input  logic [1:0]       units_i,
    input  logic [1:0]       ofs_i,
    input  logic             flush_i,
    output logic [2:0]       fill_o,
    output logic [BUS_W-1:0] word_o,
    output logic             valid_o
);
    localparam int UNIT_W     = UNIT_BYTES * 8;
    localparam int WORD_UNITS = BYTES_PER_BEAT / UNIT_BYTES;

    logic [2*BUS_W-1:0] buf_q, buf_d, merged;
    logic [BUS_W-1:0]   chunk, keep_mask, word_q, word_d;
    logic [2:0]         fill_q, fill_d, total;
    logic               valid_q, valid_d;

    always_comb begin
        keep_mask = ~({BUS_W{1'b1}} >> (units_i * UNIT_W));
        chunk     = (data_i << (ofs_i * UNIT_W)) & keep_mask;
        // Unused buffer tail is always zero, so OR-ing in the new chunk is an append.
        merged    = buf_q | ({chunk, {BUS_W{1'b0}}} >> (fill_q * UNIT_W));
        total     = fill_q + {1'b0, units_i};
        buf_d     = buf_q;
        fill_d    = fill_q;
        word_d    = word_q;
        valid_d   = 1'b0;
        if (flush_i) begin
            buf_d  = '0;
            fill_d = '0;
        end else if (push_i) begin
            if (total >= 3'(WORD_UNITS)) begin
                word_d  = merged[2*BUS_W-1 -: BUS_W];
                buf_d   = merged << BUS_W;
                fill_d  = total - 3'(WORD_UNITS);
                valid_d = 1'b1;
            end else begin
                buf_d  = merged;
                fill_d = total;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q   <= '0;
            fill_q  <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            buf_q   <= buf_d;
            fill_q  <= fill_d;
            word_q  <= word_d;
            valid_q <= valid_d;
        end
    end

    overflow_chk: assert property (@(posedge clk) disable iff (rst)
        (push_i && !flush_i) |-> fill_q <= 3'd2);

    assign fill_o  = fill_q;
    assign word_o  = word_q;
    assign valid_o = valid_q;
endmodule

// File: rtl/odu_payload_extract.sv
// rtl/odu_payload_extract.sv - ODU frame/row lock, header and stuff stripping, payload repack to 48 B words
// Optional stuff byte check: ODU_PAYLOAD_EXTRACT_STUFF_CHECK_EN
module odu_payload_extract
    import odu_pkg::*;
#(
    parameter int BEATS_PER_ROW  = 80,
    parameter int ROWS_PER_FRAME = 4,
    parameter int LOF_THRESH     = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [BUS_W-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_frame_start,
    input  logic             in_row_start,
    output logic [BUS_W-1:0] out_data,
    output logic             out_valid,
    output logic             out_sof,
    output logic [1:0]       out_sof_ofs,
    output logic             hdr_err,
    output logic             lof,
`ifdef ODU_PAYLOAD_EXTRACT_STUFF_CHECK_EN
    output logic             stuff_err,
`endif
    output logic [7:0]       psi
);
    localparam int BW = $clog2(BEATS_PER_ROW);
    localparam int RW = $clog2(ROWS_PER_FRAME);
    localparam int EW = $clog2(LOF_THRESH + 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS_PER_ROW - 1);
    localparam logic [RW-1:0] LAST_ROW  = RW'(ROWS_PER_FRAME - 1);

    odu_state_e    state_q, state_d;
    logic [BW-1:0] beat_q, beat_d, cur_beat;
    logic [RW-1:0] row_q, row_d, cur_row;
    logic [EW-1:0] ecnt_q, ecnt_d;
    logic          ferr_q, ferr_d, hdr_err_q, hdr_err_d, sof_pend_q, sof_pend_d;
    logic          sof_q, sof_d, lof_q, lof_d;
    logic [1:0]    sof_ofs_q, sof_ofs_d, units, ofs;
    logic [7:0]    psi_q, psi_d;
    logic          take, flush, mis, hdr_bad, emit;
    logic [2:0]    gb_fill;

    always_comb begin
        hdr_bad = 1'b0;
        for (int i = 0; i < HDR_BYTES; i++) begin
            if (!(cur_row == RW'(PSI_ROW) && i == PSI_BYTE_IDX) &&
                in_data[BUS_W-1-8*i -: 8] != hdr_byte(2'(cur_row)))
                hdr_bad = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        row_d      = row_q;
        ferr_d     = ferr_q;
        ecnt_d     = ecnt_q;
        hdr_err_d  = 1'b0;
        psi_d      = psi_q;
        sof_pend_d = sof_pend_q;
        sof_d      = 1'b0;
        sof_ofs_d  = sof_ofs_q;
        take       = 1'b0;
        flush      = 1'b0;
        // The HUNT entry beat is treated as row 0, beat 0.
        cur_beat   = (state_q == SYNC) ? beat_q : '0;
        cur_row    = (state_q == SYNC) ? row_q : '0;
        mis   = (beat_q != '0 && in_row_start) || (beat_q == '0 && !in_row_start) ||
                (in_frame_start && !(row_q == '0 && beat_q == '0));
        units = (cur_beat == '0 || cur_beat == LAST_BEAT) ? 2'd2 : 2'd3;
        ofs   = (cur_beat == '0) ? 2'd1 : 2'd0;
        emit  = (gb_fill + {1'b0, units}) >= 3'd3;

        if (in_valid) begin
            if (state_q == HUNT) begin
                if (in_frame_start && in_row_start) begin
                    take    = 1'b1;
                    state_d = SYNC;
                end
            end else if (mis) begin
                state_d = HUNT;
                flush   = 1'b1;
            end else begin
                take = 1'b1;
            end
        end

        if (take) begin
            if (cur_beat == '0) begin
                hdr_err_d = hdr_bad;
                ferr_d    = ferr_q | hdr_bad;
                if (cur_row == RW'(PSI_ROW))
                    psi_d = in_data[BUS_W-1-8*PSI_BYTE_IDX -: 8];
                if (cur_row == '0) begin
                    sof_pend_d = 1'b1;
                    sof_ofs_d  = gb_fill[1:0];
                end
            end
            if (emit && sof_pend_d) begin
                sof_d      = 1'b1;
                sof_pend_d = 1'b0;
            end
            if (cur_beat == LAST_BEAT) begin
                beat_d = '0;
                row_d  = (cur_row == LAST_ROW) ? '0 : cur_row + 1'b1;
                if (cur_row == LAST_ROW) begin
                    ferr_d = 1'b0;
                    if (!ferr_q)
                        ecnt_d = '0;
                    else if (ecnt_q == EW'(LOF_THRESH - 1)) begin
                        state_d = HUNT;
                        flush   = 1'b1;
                    end else
                        ecnt_d = ecnt_q + 1'b1;
                end
            end else begin
                beat_d = cur_beat + 1'b1;
                row_d  = cur_row;
            end
        end

        if (state_d == HUNT) begin
            beat_d     = '0;
            row_d      = '0;
            ferr_d     = 1'b0;
            ecnt_d     = '0;
            sof_pend_d = 1'b0;
            sof_d      = 1'b0;
        end
        lof_d = (state_d == HUNT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= HUNT;
            beat_q     <= '0;
            row_q      <= '0;
            ferr_q     <= 1'b0;
            ecnt_q     <= '0;
            hdr_err_q  <= 1'b0;
            psi_q      <= '0;
            sof_pend_q <= 1'b0;
            sof_q      <= 1'b0;
            sof_ofs_q  <= '0;
            lof_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            row_q      <= row_d;
            ferr_q     <= ferr_d;
            ecnt_q     <= ecnt_d;
            hdr_err_q  <= hdr_err_d;
            psi_q      <= psi_d;
            sof_pend_q <= sof_pend_d;
            sof_q      <= sof_d;
            sof_ofs_q  <= sof_ofs_d;
            lof_q      <= lof_d;
        end
    end

    odu_gearbox_48b u_gearbox (
        .clk     (clk),
        .rst     (rst),
        .push_i  (take),
        .data_i  (in_data),
        .units_i (units),
        .ofs_i   (ofs),
        .flush_i (flush),
        .fill_o  (gb_fill),
        .word_o  (out_data),
        .valid_o (out_valid)
    );

`ifdef ODU_PAYLOAD_EXTRACT_STUFF_CHECK_EN
    logic stuff_bad, stuff_err_q;
    always_comb begin
        stuff_bad = 1'b0;
        for (int i = BYTES_PER_BEAT - STUFF_BYTES; i < BYTES_PER_BEAT; i++)
            if (in_data[BUS_W-1-8*i -: 8] != STUFF_BYTE) stuff_bad = 1'b1;
    end
    always_ff @(posedge clk) begin
        if (rst) stuff_err_q <= 1'b0;
        else     stuff_err_q <= take && cur_beat == LAST_BEAT && stuff_bad;
    end
    assign stuff_err = stuff_err_q;
`endif

    assign out_sof     = sof_q;
    assign out_sof_ofs = sof_ofs_q;
    assign hdr_err     = hdr_err_q;
    assign lof         = lof_q;
    assign psi         = psi_q;
endmodule

// File: tb/tb_odu_payload_extract.sv
// tb/tb_odu_payload_extract.sv - self-checking bench for odu_payload_extract
module tb_odu_payload_extract;
    localparam int BEATS  = 80;
    localparam int ROWS   = 4;
    localparam int THRESH = 3;
    localparam int FRAME  = BEATS * ROWS;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [383:0] in_data = '0;
    logic         in_valid = 1'b0, in_frame_start = 1'b0, in_row_start = 1'b0;
    logic [383:0] out_data;
    logic         out_valid, out_sof, hdr_err, lof;
    logic [1:0]   out_sof_ofs;
    logic [7:0]   psi;
`ifdef ODU_PAYLOAD_EXTRACT_STUFF_CHECK_EN
    logic         stuff_err;
`endif

    always #5 clk = ~clk;

    odu_payload_extract #(.BEATS_PER_ROW(BEATS), .ROWS_PER_FRAME(ROWS), .LOF_THRESH(THRESH)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_frame_start(in_frame_start), .in_row_start(in_row_start),
        .out_data(out_data), .out_valid(out_valid), .out_sof(out_sof), .out_sof_ofs(out_sof_ofs),
        .hdr_err(hdr_err), .lof(lof),
`ifdef ODU_PAYLOAD_EXTRACT_STUFF_CHECK_EN
        .stuff_err(stuff_err),
`endif
        .psi(psi)
    );

    int total = 0, bad = 0;
    int n_valid = 0, n_hdr = 0, n_stuff = 0;

    task automatic chk(string name, logic [383:0] act, logic [383:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: payload bytes queue, emitted 48 at a time.
    bit           m_sync;
    int           m_row, m_beat, m_ecnt, m_sof_idx;
    bit           m_ferr;
    byte unsigned pend[$];
    logic [383:0] m_word;
    logic [7:0]   m_psi;
    bit           e_valid, e_sof, e_hdr, e_stuff;
    int           e_ofs;

    function automatic logic [7:0] byte_at(logic [383:0] d, int i);
        return d[383-8*i -: 8];
    endfunction

    function automatic logic [383:0] rand_beat();
        logic [383:0] d;
        for (int i = 0; i < 48; i++) d[383-8*i -: 8] = 8'($urandom);
        return d;
    endfunction

    task automatic go_hunt();
        m_sync = 0; m_row = 0; m_beat = 0; m_ferr = 0; m_ecnt = 0; m_sof_idx = -1;
        pend.delete();
    endtask

    task automatic model_reset();
        go_hunt();
        m_word = '0;
        m_psi  = '0;
    endtask

    task automatic model_step(bit v, bit fs, bit rs, logic [383:0] d);
        bit acc = 0;
        int n0, n1;
        e_valid = 0; e_sof = 0; e_hdr = 0; e_stuff = 0; e_ofs = 0;
        if (!v) return;
        if (!m_sync) begin
            if (fs && rs) begin m_sync = 1; m_row = 0; m_beat = 0; acc = 1; end
        end else if ((m_beat != 0 && rs) || (m_beat == 0 && !rs) || (fs && !(m_row == 0 && m_beat == 0)))
            go_hunt();
        else
            acc = 1;
        if (!acc) return;
        if (m_beat == 0) begin
            for (int i = 0; i < 16; i++)
                if (!(m_row == 3 && i == 14) && byte_at(d, i) != 8'(8'h11 * (m_row + 1))) e_hdr = 1;
            m_ferr = m_ferr | e_hdr;
            if (m_row == 3) m_psi = byte_at(d, 14);
            if (m_row == 0) m_sof_idx = pend.size();
            n0 = 16; n1 = 48;
        end else if (m_beat == BEATS - 1) begin
            for (int i = 32; i < 48; i++) if (byte_at(d, i) != 8'h99) e_stuff = 1;
            n0 = 0; n1 = 32;
        end else begin
            n0 = 0; n1 = 48;
        end
        for (int i = n0; i < n1; i++) pend.push_back(byte_at(d, i));
        if (m_beat == BEATS - 1 && m_row == ROWS - 1) begin
            m_ecnt = m_ferr ? m_ecnt + 1 : 0;
            m_ferr = 0;
            if (m_ecnt >= THRESH) begin go_hunt(); return; end
        end
        m_beat++;
        if (m_beat == BEATS) begin m_beat = 0; m_row = (m_row + 1) % ROWS; end
        if (pend.size() >= 48) begin
            for (int i = 0; i < 48; i++) m_word[383-8*i -: 8] = pend.pop_front();
            e_valid = 1;
            if (m_sof_idx >= 0 && m_sof_idx < 48) begin e_sof = 1; e_ofs = m_sof_idx / 16; end
            m_sof_idx = (m_sof_idx >= 48) ? m_sof_idx - 48 : -1;
        end
    endtask

    task automatic drive(bit v, bit fs, bit rs, logic [383:0] d);
        @(negedge clk);
        in_valid = v; in_frame_start = fs; in_row_start = rs; in_data = d;
        model_step(v, fs, rs, d);
        @(posedge clk); #1;
        chk("out_valid", out_valid, e_valid);
        chk("out_data", out_data, m_word);
        chk("out_sof", out_sof, e_sof);
        if (e_sof) chk("out_sof_ofs", out_sof_ofs, e_ofs);
        chk("hdr_err", hdr_err, e_hdr);
        chk("lof", lof, !m_sync);
        chk("psi", psi, m_psi);
        if (out_valid) n_valid++;
        if (hdr_err) n_hdr++;
`ifdef ODU_PAYLOAD_EXTRACT_STUFF_CHECK_EN
        chk("stuff_err", stuff_err, e_stuff);
        if (stuff_err) n_stuff++;
`endif
    endtask

    task automatic idle(int n);
        for (int k = 0; k < n; k++) drive(0, 1'($urandom), 1'($urandom), rand_beat());
    endtask

    task automatic check_reset(string tag);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_out_sof"}, out_sof, 0);
        chk({tag, "_out_sof_ofs"}, out_sof_ofs, 0);
        chk({tag, "_hdr_err"}, hdr_err, 0);
        chk({tag, "_lof"}, lof, 1);
        chk({tag, "_psi"}, psi, 0);
`ifdef ODU_PAYLOAD_EXTRACT_STUFF_CHECK_EN
        chk({tag, "_stuff_err"}, stuff_err, 0);
`endif
    endtask

    // Source generator position.
    int         g_row = 0, g_beat = 0;
    logic [7:0] g_psi = 8'h00;

    function automatic logic [383:0] hdr_beat(int row, int bad_idx);
        logic [383:0] d = rand_beat();
        for (int i = 0; i < 16; i++) d[383-8*i -: 8] = 8'(8'h11 * (row + 1));
        if (bad_idx >= 0) d[383-8*bad_idx -: 8] = 8'h00;
        return d;
    endfunction

    task automatic g_adv();
        g_beat++;
        if (g_beat == BEATS) begin g_beat = 0; g_row = (g_row + 1) % ROWS; end
    endtask

    task automatic send_beats(int n, int bad_row = -1, int bad_byte = -1, int inj_row = -1,
                              int inj_beat = -1, int stuff_row = -1, bit gaps = 0);
        for (int k = 0; k < n; k++) begin
            logic [383:0] d;
            bit fs, rs;
            if (gaps && $urandom_range(0, 19) == 0) idle($urandom_range(1, 3));
            d  = rand_beat();
            rs = (g_beat == 0);
            fs = (g_beat == 0 && g_row == 0) || (g_row == inj_row && g_beat == inj_beat);
            if (g_beat == 0) begin
                if (g_row == 0) g_psi = 8'($urandom);
                d = hdr_beat(g_row, -1);
                if (g_row == 3) d[383-8*14 -: 8] = g_psi;
                if (g_row == bad_row) d[383-8*bad_byte -: 8] = 8'h00;
            end
            if (g_beat == BEATS - 1) begin
                for (int i = 32; i < 48; i++) d[383-8*i -: 8] = 8'h99;
                if (g_row == stuff_row) d[383-8*33 -: 8] = 8'h00;
            end
            drive(1, fs, rs, d);
            g_adv();
        end
    endtask

    typedef struct {
        bit v; bit fs; bit rs; int bad_idx;
        bit e_lof; bit e_hdr;
    } vec_t;
    vec_t vt[8];

    initial begin
        vt[0] = '{1, 1, 1, -1, 0, 0};
        vt[1] = '{1, 1, 1,  0, 0, 1};
        vt[2] = '{1, 1, 1, 15, 0, 1};
        vt[3] = '{1, 1, 1, 14, 0, 1};
        vt[4] = '{1, 1, 1,  7, 0, 1};
        vt[5] = '{1, 1, 0, -1, 1, 0};
        vt[6] = '{1, 0, 1, -1, 1, 0};
        vt[7] = '{0, 1, 1, -1, 1, 0};

        model_reset();
        repeat (3) @(posedge clk);
        #1 check_reset("rst0");

        // Single entry-beat vectors from reset.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rst = 1'b0;
            in_valid = vt[i].v; in_frame_start = vt[i].fs; in_row_start = vt[i].rs;
            in_data = hdr_beat(0, vt[i].bad_idx);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_lof", i), lof, vt[i].e_lof);
            chk($sformatf("vec%0d_hdr_err", i), hdr_err, vt[i].e_hdr);
            chk($sformatf("vec%0d_out_valid", i), out_valid, 0);
            @(negedge clk);
            in_valid = 1'b0;
            @(posedge clk); #1;
            chk($sformatf("vec%0d_hdr_pulse", i), hdr_err, 0);
            @(negedge clk);
            rst = 1'b1;
            @(posedge clk);
        end
        #1 check_reset("rst1");
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        model_reset();

        // Clean stream: 3 rows give exactly 238 words.
        n_valid = 0; n_hdr = 0;
        send_beats(3 * BEATS);
        chk("words_3rows", n_valid, 238);
        send_beats(BEATS);
        send_beats(40);
        idle(5);
        send_beats(FRAME - 40);
        send_beats(FRAME, -1, -1, -1, -1, -1, 1);
        chk("clean_hdr_err_count", n_hdr, 0);
        chk("clean_lof", lof, 0);

        // One header error: single pulse, sync held.
        n_hdr = 0;
        send_beats(FRAME, 1, 5);
        chk("hdr_err_count", n_hdr, 1);
        chk("hdr_err_lof", lof, 0);
        send_beats(FRAME);

        // Three consecutive error frames force loss of frame; then reacquire.
        send_beats(FRAME, 2, 3);
        send_beats(FRAME, 0, 9);
        chk("lof_after_2", lof, 0);
        send_beats(FRAME, 3, 1);
        chk("lof_after_3", lof, 1);
        send_beats(FRAME);
        chk("lof_reacq", lof, 0);

        // Stray frame start mid-row.
        send_beats(BEATS + 41, -1, -1, 1, 40);
        chk("lof_misalign", lof, 1);
        n_valid = 0;
        send_beats(FRAME - BEATS - 41);
        chk("no_words_in_hunt", n_valid, 0);
        send_beats(FRAME);
        chk("lof_misalign_reacq", lof, 0);

`ifdef ODU_PAYLOAD_EXTRACT_STUFF_CHECK_EN
        n_stuff = 0;
        send_beats(FRAME, -1, -1, -1, -1, 2);
        chk("stuff_err_count", n_stuff, 1);
        chk("stuff_lof", lof, 0);
`endif

        // Randomised frames with gaps and sporadic header errors.
        for (int f = 0; f < 4; f++) begin
            int br = $urandom_range(0, 7);
            send_beats(FRAME, (br < 4) ? br : -1, $urandom_range(0, 15), -1, -1, -1, 1);
        end

        // Reset mid-row discards everything.
        while (g_beat != 0 || g_row != 0) send_beats(1);
        send_beats(BEATS + 30);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; in_frame_start = 1'b0; in_row_start = 1'b0; in_data = rand_beat();
        g_adv();
        @(posedge clk);
        #1 check_reset("rst_mid");
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        model_reset();
        send_beats(2 * FRAME, -1, -1, -1, -1, -1, 1);
        chk("lof_after_rst", lof, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
